rcv_fifo_ctrl: RTL

RCV_FIFO_CTRL -- requirements
Module: rcv_fifo_ctrl

---
 rtl/rcv_fifo_ctrl.sv | 64 ++++++
 1 files changed

// File: rtl/rcv_fifo_ctrl.sv
// rcv_fifo_ctrl: packs received bytes into 32-bit words and drives the write/read
// pointers of a 4-entry word FIFO, flagging short packets and dropped words.
module rcv_fifo_ctrl (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_eop,
  input  logic        read_en,
  input  logic        clear,
  output logic        wr_en,
  output logic [1:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [1:0]  rd_addr,
  output logic        full,
  output logic        empty,
  output logic        framing_error,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, RECV, ERR} state_t;
  state_t state, state_nx;
  logic [1:0] head_ptr, tail_ptr, tail_side, side_nx, lanes;
  logic head_tog, tail_tog, lane3, push, eop_act, eop_err;
  logic [23:0] hold;
  assign empty   = head_ptr == tail_ptr && head_tog == tail_tog;
  assign full    = head_ptr == tail_ptr && head_tog != tail_tog;
  assign rd_addr = head_ptr;
  assign side_nx = tail_side + 2'd1;
  assign lane3   = rx_byte_valid && tail_side == 2'd3;
  assign push    = lane3 && !full;
  // eop sees the lane count after any coincident byte has been counted
  assign lanes   = rx_byte_valid ? side_nx : tail_side;
  assign eop_act = rx_eop && (rx_byte_valid || state == RECV);
  assign eop_err = eop_act && lanes != 2'd0;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = clear ? IDLE : eop_act ? (eop_err ? ERR : IDLE) : rx_byte_valid ? RECV : state;
  always_comb
    framing_error = state == ERR;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      {head_tog, head_ptr, tail_tog, tail_ptr, tail_side} <= '0;
      {hold, wr_en, wr_addr, wr_data, overflow} <= '0;
    end else if (clear) begin
      {head_tog, head_ptr, tail_tog, tail_ptr, tail_side} <= '0;
      {hold, wr_en, wr_addr, wr_data, overflow} <= '0;
    end else begin
      wr_en <= push;
      if (push) begin
        wr_addr <= tail_ptr;
        wr_data <= {rx_byte, hold};
      end
      // the pointer moves only once the write strobe has been presented
      if (wr_en) {tail_tog, tail_ptr} <= {tail_tog, tail_ptr} + 3'd1;
      if (read_en && !empty) {head_tog, head_ptr} <= {head_tog, head_ptr} + 3'd1;
      if (lane3 && full) overflow <= 1'b1;
      tail_side <= eop_err ? 2'd0 : lanes;
      if (rx_byte_valid && !lane3) hold[{tail_side, 3'b000} +: 8] <= rx_byte;
      if (eop_err) hold <= '0;
    end
  end
endmodule
